led_blink_arbiter: RTL and testbench
====================================

Name: led_blink_arbiter

Overview:
- Shares the board's single status LED between NREQ requesters. Each requester asks for a blink code of N pulses.
- A round-robin arbiter grants one requester at a time. A timing FSM then plays that requester's pattern: N on/off pulses followed by a dark gap.
- The block acknowledges the requester when the pattern finishes.
- It sits between the design's status sources and the LED pin and replaces free-running counter blinkers.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CNT_W, 4, width of each requester's pulse count.
- TICK_DIV, 12000, clk cycles per timing tick (1 ms at 12 MHz).
- ON_TICKS, 200, ticks the LED is on per pulse (>=1).
- OFF_TICKS, 200, ticks the LED is off between pulses (>=1).
- GAP_TICKS, 800, ticks of dark gap after the last pulse (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  request per requester. Level signal, held until ack.
- count  in  NREQ*CNT_W  pulse count. Requester i uses bits [i*CNT_W +: CNT_W]. Sampled only at grant.
- ack  out  NREQ  one-cycle completion pulse for the served requester.
- busy  out  1  high while a pattern is in progress, i.e. the state is not IDLE.
- grant_id  out  clog2(NREQ)  index of the current or last granted requester.
- led  out  1  LED drive, active-high, registered.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; led=0, ack=0, busy=0, grant_id=0.
  - RR pointer=0; prescaler and tick counter cleared.
  - Asserting reset mid-pattern aborts it immediately with no ack.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick pulses when it wraps.
  - Cleared on every state transition, so each phase lasts exactly PHASE_TICKS*TICK_DIV cycles.
- States: IDLE, ON, OFF, GAP.
- IDLE:
  - Round-robin search of req starting at the pointer, ascending, wrapping modulo NREQ.
  - On a hit: latch grant_id and count[grant_id] into a remaining counter.
  - Next cycle: state=ON, led=1, busy=1.
  - If the latched count is 0, go directly to GAP with led held at 0.
- ON:
  - led=1 for ON_TICKS*TICK_DIV cycles, then OFF.
  - remaining decrements on the ON->OFF transition.
- OFF:
  - led=0 for OFF_TICKS*TICK_DIV cycles.
  - Then ON if remaining!=0, else GAP.
- GAP:
  - led=0 for GAP_TICKS*TICK_DIV cycles, then IDLE.
  - On entry to IDLE, ack[grant_id]=1 for exactly that one cycle and busy=0.
  - Pointer becomes grant_id+1 mod NREQ.
- Ack-cycle mask:
  - In the cycle ack is high, req[grant_id] is ignored for arbitration, since the requester is still dropping it.
  - Other requesters may be granted in that same cycle.
  - A requester that keeps req high past the ack cycle is served again when the RR search next reaches it.
- Pattern length: N*(ON_TICKS+OFF_TICKS)*TICK_DIV + GAP_TICKS*TICK_DIV cycles, measured from the first led=1 cycle to the ack cycle exclusive.
- Request handling during a pattern:
  - Changes to req or count of the active requester are ignored.
  - Deasserting req mid-pattern does not abort; ack still pulses.
- Simultaneous requests: the lowest index at or above the pointer wins. The others wait, with no loss.
- Count handling: count=2^CNT_W-1 gives the maximum number of pulses, with no wrap of remaining.
- ack is never asserted for a requester that was not granted. At most one ack bit is high in any cycle.

Test Plan (TICK_DIV=2, ON_TICKS=3, OFF_TICKS=2, GAP_TICKS=4, NREQ=4):
- Reset checks: hold rst_n=0 with req=4'b1111 -> led=0, ack=0, busy=0, grant_id=0.
- Single request: release reset; req[1]=1, count1=2 -> led high 6 cycles, low 4, high 6, low 4, then low 8. ack[1] pulses on cycle 28 after the first led=1 cycle; busy=0 that cycle; grant_id=1.
- Round-robin: req=4'b1011 all held, all counts=1 -> served order 0,1,3,0. Each ack is a one-cycle pulse. Exactly one pattern is in flight at a time.
- Zero count: req[2]=1, count2=0 -> led stays 0. ack[2] pulses 8 cycles after the grant cycle +1.
- Abort: reset asserted mid-ON of a count=3 pattern -> led=0 and busy=0 asynchronously. No ack. After release, a new req[0] is served from pointer 0.
- Request changes mid-pattern: req[3] dropped and count3 changed mid-pattern -> the original pulse count completes and ack[3] still pulses once.

Source files
------------

// File: rtl/led_blink_arbiter.sv
// Shares one status LED between NREQ requesters, playing each requester's
// N-pulse blink code in round-robin order and acknowledging on completion.
module led_blink_arbiter #(
  parameter int NREQ      = 4,
  parameter int CNT_W     = 4,
  parameter int TICK_DIV  = 12000,
  parameter int ON_TICKS  = 200,
  parameter int OFF_TICKS = 200,
  parameter int GAP_TICKS = 800
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*CNT_W-1:0]    count,
  output logic [NREQ-1:0]          ack,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     led
);

  localparam int ID_W    = $clog2(NREQ);
  localparam int MAX_OF  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAX_T   = (MAX_OF > GAP_TICKS) ? MAX_OF : GAP_TICKS;
  localparam int TCNT_W  = $clog2(MAX_T + 1);
  localparam int PRESC_W = $clog2(TICK_DIV + 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [CNT_W-1:0]    remain_q, remain_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic                led_q, led_d;

  logic [CNT_W-1:0]    cnt_arr [NREQ];
  logic [NREQ-1:0]     req_masked;
  logic                hit;
  logic [ID_W-1:0]     pick;
  logic [ID_W:0]       scan_sum;
  logic                tick;
  logic [TCNT_W-1:0]   phase_last;
  logic                phase_done;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
    assign cnt_arr[gi] = count[gi*CNT_W +: CNT_W];
  end

  // During the ack cycle ack_q is one-hot on the requester just served,
  // so it doubles as the mask for its still-falling request.
  assign req_masked = req & ~ack_q;

  always_comb begin
    hit      = 1'b0;
    pick     = '0;
    scan_sum = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NREQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(NREQ);
      end
      if (!hit && req_masked[scan_sum[ID_W-1:0]]) begin
        hit  = 1'b1;
        pick = scan_sum[ID_W-1:0];
      end
    end
  end

  assign tick = (presc_q == PRESC_W'(TICK_DIV - 1));

  always_comb begin
    phase_last = '0;
    case (state_q)
      S_ON:    phase_last = TCNT_W'(ON_TICKS - 1);
      S_OFF:   phase_last = TCNT_W'(OFF_TICKS - 1);
      S_GAP:   phase_last = TCNT_W'(GAP_TICKS - 1);
      default: phase_last = '0;
    endcase
  end

  assign phase_done = tick && (tcnt_q == phase_last);

  always_comb begin
    state_d  = state_q;
    presc_d  = tick ? '0 : presc_q + PRESC_W'(1);
    tcnt_d   = tick ? tcnt_q + TCNT_W'(1) : tcnt_q;
    remain_d = remain_q;
    gid_d    = gid_q;
    ptr_d    = ptr_q;
    ack_d    = '0;
    led_d    = led_q;

    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        tcnt_d  = '0;
        if (hit) begin
          gid_d    = pick;
          remain_d = cnt_arr[pick];
          if (cnt_arr[pick] == '0) begin
            state_d = S_GAP;
            led_d   = 1'b0;
          end else begin
            state_d = S_ON;
            led_d   = 1'b1;
          end
        end
      end
      S_ON: begin
        if (phase_done) begin
          state_d  = S_OFF;
          led_d    = 1'b0;
          remain_d = remain_q - CNT_W'(1);
          presc_d  = '0;
          tcnt_d   = '0;
        end
      end
      S_OFF: begin
        if (phase_done) begin
          presc_d = '0;
          tcnt_d  = '0;
          if (remain_q != '0) begin
            state_d = S_ON;
            led_d   = 1'b1;
          end else begin
            state_d = S_GAP;
            led_d   = 1'b0;
          end
        end
      end
      S_GAP: begin
        if (phase_done) begin
          state_d      = S_IDLE;
          led_d        = 1'b0;
          presc_d      = '0;
          tcnt_d       = '0;
          ack_d[gid_q] = 1'b1;
          ptr_d        = (gid_q == ID_W'(NREQ - 1)) ? '0 : gid_q + ID_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        led_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      tcnt_q   <= '0;
      remain_q <= '0;
      gid_q    <= '0;
      ptr_q    <= '0;
      ack_q    <= '0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      tcnt_q   <= tcnt_d;
      remain_q <= remain_d;
      gid_q    <= gid_d;
      ptr_q    <= ptr_d;
      ack_q    <= ack_d;
      led_q    <= led_d;
    end
  end

  assign ack      = ack_q;
  assign busy     = (state_q != S_IDLE);
  assign grant_id = gid_q;
  assign led      = led_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Directed bench for led_blink_arbiter with short timing parameters
// (TICK_DIV=2, ON=3, OFF=2, GAP=4): one pulse = 10 cycles, gap = 8 cycles.
module tb_led_blink_arbiter;

  localparam int NREQ = 4;
  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*CNT_W-1:0] count;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic [1:0]        grant_id;
  logic              led;

  int n_assert = 0;
  int n_fail   = 0;

  led_blink_arbiter #(
    .NREQ(NREQ), .CNT_W(CNT_W), .TICK_DIV(2),
    .ON_TICKS(3), .OFF_TICKS(2), .GAP_TICKS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .count(count),
    .ack(ack), .busy(busy), .grant_id(grant_id), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string tag, input int bound, output int n);
    n = 0;
    while (ack == '0 && n < bound) begin
      step();
      n++;
    end
    chk({tag, "_ack_seen"}, 32'(|ack), 32'd1);
  endtask

  task automatic wait_led(input string tag, input int bound, output int n);
    n = 0;
    while (!led && n < bound) begin
      step();
      n++;
    end
    chk({tag, "_led_seen"}, 32'(led), 32'd1);
  endtask

  int n;
  int rises;
  logic prev;
  logic [27:0] trace;
  logic [3:0] acc;
  logic lacc;
  logic [3:0] exp_ack;
  int order [4] = '{0, 1, 3, 0};

  initial begin
    // Reset held with every requester asking
    rst_n = 1'b0;
    req   = 4'b1111;
    count = 16'h1111;
    repeat (3) step();
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    req   = '0;
    rst_n = 1'b1;
    step();

    // Single request, two pulses
    req   = 4'b0010;
    count = 16'h0020;
    wait_led("single", 10, n);
    chk("single_latency", 32'(n), 32'd1);
    chk("single_gid", 32'(grant_id), 32'd1);
    acc = '0;
    for (int i = 0; i < 28; i++) begin
      trace[i] = led;
      acc |= ack;
      step();
    end
    chk("single_trace", 32'(trace), 32'h000FC3F);
    chk("single_no_early_ack", 32'(acc), 32'd0);
    chk("single_ack", 32'(ack), 32'b0010);
    chk("single_ack_busy", 32'(busy), 32'd0);
    chk("single_ack_gid", 32'(grant_id), 32'd1);
    req = '0;
    step();
    chk("single_ack_once", 32'(ack), 32'd0);

    // Reset pulse brings the RR pointer back to 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Round robin among 0,1,3 with all counts 1
    count = 16'h1111;
    req   = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      wait_ack("rr", 40, n);
      if (k > 0) chk("rr_period", 32'(n), 32'd18);
      exp_ack = 4'b0001 << order[k];
      chk("rr_ack", 32'(ack), 32'(exp_ack));
      chk("rr_gid", 32'(grant_id), 32'(order[k]));
      chk("rr_ack_busy", 32'(busy), 32'd0);
      if (k == 3) req = '0;
      step();
      chk("rr_ack_pulse", 32'(ack), 32'd0);
      chk("rr_busy_next", 32'(busy), 32'(k < 3));
    end

    // Zero count: dark gap only
    req   = 4'b0100;
    count = 16'h0000;
    n = 0;
    lacc = 1'b0;
    while (ack == '0 && n < 20) begin
      step();
      n++;
      lacc |= led;
    end
    chk("zero_len", 32'(n), 32'd9);
    chk("zero_ack", 32'(ack), 32'b0100);
    chk("zero_led_dark", 32'(lacc), 32'd0);
    req = '0;
    step();

    // Request dropped and count changed mid-pattern
    req   = 4'b1000;
    count = 16'h2000;
    wait_led("chg", 10, n);
    chk("chg_gid", 32'(grant_id), 32'd3);
    acc = '0;
    for (int i = 0; i < 28; i++) begin
      trace[i] = led;
      acc |= ack;
      if (i == 3) begin
        req   = '0;
        count = 16'h5000;
      end
      step();
    end
    chk("chg_trace", 32'(trace), 32'h000FC3F);
    chk("chg_no_early_ack", 32'(acc), 32'd0);
    chk("chg_ack", 32'(ack), 32'b1000);
    acc = '0;
    lacc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      acc |= ack;
      lacc |= busy;
    end
    chk("chg_ack_once", 32'(acc), 32'd0);
    chk("chg_idle_after", 32'(lacc), 32'd0);

    // Abort mid-ON with asynchronous reset
    req   = 4'b0001;
    count = 16'h0003;
    wait_led("abort", 10, n);
    step();
    step();
    chk("abort_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_led", 32'(led), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    req = '0;
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      acc |= ack;
    end
    chk("abort_no_ack", 32'(acc), 32'd0);
    rst_n = 1'b1;
    step();

    // Post-abort service of 0, then maximum count on 2
    req   = 4'b0101;
    count = 16'h0F01;
    wait_ack("post", 40, n);
    chk("post_len", 32'(n), 32'd19);
    chk("post_ack", 32'(ack), 32'b0001);
    chk("post_gid", 32'(grant_id), 32'd0);
    req = 4'b0100;
    step();
    chk("max_first_led", 32'(led), 32'd1);
    chk("max_gid", 32'(grant_id), 32'd2);
    n = 0;
    rises = 0;
    prev = 1'b0;
    while (ack == '0 && n < 300) begin
      if (led && !prev) rises++;
      prev = led;
      step();
      n++;
    end
    chk("max_len", 32'(n), 32'd158);
    chk("max_pulses", 32'(rises), 32'd15);
    chk("max_ack", 32'(ack), 32'b0100);
    req = '0;
    step();
    chk("max_ack_once", 32'(ack), 32'd0);
    chk("max_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
